// File: rtl/rx_block_fifo_pkg.sv
// Shared defaults for the receive block buffer and its FIFO.
package rx_block_fifo_pkg;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_BLOCK_BYTES = 16;
    localparam int DEF_DEPTH       = 4;

    // Width of a word counter able to hold 0..n.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/rx_block_fifo_fifo.sv
// Synchronous single-clock block FIFO with registered read port and occupancy count.
module block_fifo
    import rx_block_fifo_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         pop,
    output logic                         push_ok,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         rd_valid,
    output logic                         empty,
    output logic                         full,
    output logic [cnt_width(DEPTH)-1:0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] rd_data_reg;
    logic             rd_valid_reg;
    logic             pop_ok;

    // Flags derive from the registered count only.
    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign pop_ok  = pop && !empty;
    // A slot freed by a same-cycle pop can take the incoming block.
    assign push_ok = push && (!full || pop_ok);

    // Block storage; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers, occupancy and registered read port.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= pop_ok;
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg  <= rd_ptr_reg + 1'b1;
                rd_data_reg <= mem[rd_ptr_reg];
            end
            if (push_ok && !pop_ok) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    assign count    = count_reg;
    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;

endmodule

// File: rtl/rx_block_fifo.sv
// Packs received words into blocks and queues complete blocks for the AES core.
module rx_block_fifo
    import rx_block_fifo_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int BLOCK_BYTES = DEF_BLOCK_BYTES,
    parameter int DEPTH       = DEF_DEPTH,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [DATA_W-1:0]                    din,
    input  logic                                 din_valid,
    input  logic                                 clear,
    input  logic                                 read_en,
    input  logic                                 clr_of,
    output logic [DATA_W*BLOCK_BYTES-1:0]        dout,
    output logic                                 dout_valid,
    output logic                                 empty,
    output logic                                 full,
    output logic [cnt_width(DEPTH)-1:0]          count,
    output logic [cnt_width(BLOCK_BYTES)-1:0]    byte_cnt,
    output logic                                 of
);

    localparam int BW  = DATA_W * BLOCK_BYTES;
    localparam int BCW = cnt_width(BLOCK_BYTES);

    logic [BW-1:0]  asm_reg, asm_next;
    logic [BCW-1:0] byte_cnt_reg, byte_cnt_next;
    logic           of_reg, of_next;
    logic [BW-1:0]  asm_base;
    logic [BCW-1:0] cnt_base;
    logic [BW-1:0]  asm_shifted;
    logic           push;
    logic           push_ok;

    // Clear takes effect before the word arriving in the same cycle.
    assign asm_base = clear ? '0 : asm_reg;
    assign cnt_base = clear ? '0 : byte_cnt_reg;

    // Word insertion point depends on the selected byte order.
    generate
        if (MSB_FIRST) begin : g_msb_first
            logic [BW+DATA_W-1:0] cat;
            assign cat         = {asm_base, din};
            assign asm_shifted = cat[BW-1:0];
        end else begin : g_lsb_first
            logic [BW+DATA_W-1:0] cat;
            assign cat         = {din, asm_base};
            assign asm_shifted = cat[BW+DATA_W-1:DATA_W];
        end
    endgenerate

    // Assembler next state, block completion and sticky overflow.
    always_comb begin
        asm_next      = asm_base;
        byte_cnt_next = cnt_base;
        push          = 1'b0;
        if (din_valid) begin
            if (cnt_base == BCW'(BLOCK_BYTES - 1)) begin
                push          = 1'b1;
                asm_next      = '0;
                byte_cnt_next = '0;
            end else begin
                asm_next      = asm_shifted;
                byte_cnt_next = cnt_base + 1'b1;
            end
        end
        // A drop in the same cycle as clr_of wins so it is never missed.
        of_next = (of_reg && !clr_of) || (push && !push_ok);
    end

    // Assembler and overflow state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            asm_reg      <= '0;
            byte_cnt_reg <= '0;
            of_reg       <= 1'b0;
        end else begin
            asm_reg      <= asm_next;
            byte_cnt_reg <= byte_cnt_next;
            of_reg       <= of_next;
        end
    end

    block_fifo #(
        .WIDTH (BW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .wr_data  (asm_shifted),
        .pop      (read_en),
        .push_ok  (push_ok),
        .rd_data  (dout),
        .rd_valid (dout_valid),
        .empty    (empty),
        .full     (full),
        .count    (count)
    );

    assign byte_cnt = byte_cnt_reg;
    assign of       = of_reg;

endmodule

// File: tb/tb_rx_block_fifo.sv
// Directed bench for rx_block_fifo: MSB-first and LSB-first instances share stimulus.
module tb_rx_block_fifo;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   din;
    logic         din_valid;
    logic         clear;
    logic         read_en;
    logic         clr_of;

    logic [127:0] dout, dout_l;
    logic         dout_valid, dout_valid_l;
    logic         empty, empty_l;
    logic         full, full_l;
    logic [2:0]   count, count_l;
    logic [4:0]   byte_cnt, byte_cnt_l;
    logic         of, of_l;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rx_block_fifo #(.DATA_W(8), .BLOCK_BYTES(16), .DEPTH(4), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .clear(clear),
        .read_en(read_en), .clr_of(clr_of), .dout(dout), .dout_valid(dout_valid),
        .empty(empty), .full(full), .count(count), .byte_cnt(byte_cnt), .of(of)
    );

    rx_block_fifo #(.DATA_W(8), .BLOCK_BYTES(16), .DEPTH(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .clear(clear),
        .read_en(read_en), .clr_of(clr_of), .dout(dout_l), .dout_valid(dout_valid_l),
        .empty(empty_l), .full(full_l), .count(count_l), .byte_cnt(byte_cnt_l), .of(of_l)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        din       = b;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    // Block k consists of bytes k*16+0 .. k*16+15 in arrival order.
    task automatic send_block(input int k);
        for (int i = 0; i < 16; i++) send_byte(8'(k * 16 + i));
    endtask

    // Expected MSB-first image of block k, e.g. k=1 -> 101112..1F.
    function automatic logic [127:0] blk(input int k);
        logic [127:0] v = '0;
        for (int i = 0; i < 16; i++) v = {v[119:0], 8'(k * 16 + i)};
        return v;
    endfunction

    task automatic pop_check(input string tag, input logic [127:0] exp);
        read_en = 1'b1;
        tick();
        read_en = 1'b0;
        check({tag, "_valid"}, 128'(dout_valid), 128'd1);
        check({tag, "_dout"}, dout, exp);
    endtask

    initial begin
        reset = 1'b1; din = '0; din_valid = 1'b0; clear = 1'b0; read_en = 1'b0; clr_of = 1'b0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        check("rst_dout", dout, '0);
        check("rst_dout_valid", 128'(dout_valid), 128'd0);
        check("rst_empty", 128'(empty), 128'd1);
        check("rst_full", 128'(full), 128'd0);
        check("rst_count", 128'(count), 128'd0);
        check("rst_byte_cnt", 128'(byte_cnt), 128'd0);
        check("rst_of", 128'(of), 128'd0);

        // Byte order: 00,11,...,FF
        for (int i = 0; i < 15; i++) send_byte(8'(i * 17));
        check("bo_byte_cnt15", 128'(byte_cnt), 128'd15);
        check("bo_empty_partial", 128'(empty), 128'd1);
        send_byte(8'hFF);
        check("bo_byte_cnt_wrap", 128'(byte_cnt), 128'd0);
        check("bo_count", 128'(count), 128'd1);
        check("bo_empty", 128'(empty), 128'd0);
        read_en = 1'b1;
        tick();
        read_en = 1'b0;
        check("bo_msb_valid", 128'(dout_valid), 128'd1);
        check("bo_msb_dout", dout, 128'h00112233445566778899AABBCCDDEEFF);
        check("bo_lsb_valid", 128'(dout_valid_l), 128'd1);
        check("bo_lsb_dout", dout_l, 128'hFFEEDDCCBBAA99887766554433221100);
        check("bo_empty_after", 128'(empty), 128'd1);
        tick();
        check("bo_valid_drop", 128'(dout_valid), 128'd0);

        // Underflow: read on empty
        read_en = 1'b1;
        tick();
        read_en = 1'b0;
        check("uf_valid", 128'(dout_valid), 128'd0);
        check("uf_dout_hold", dout, 128'h00112233445566778899AABBCCDDEEFF);
        check("uf_count", 128'(count), 128'd0);
        check("uf_of", 128'(of), 128'd0);

        // Overflow: 5 blocks, clr_of coincides with the dropping word
        for (int k = 1; k <= 4; k++) send_block(k);
        check("ov_full4", 128'(full), 128'd1);
        for (int i = 0; i < 15; i++) send_byte(8'(80 + i));
        clr_of = 1'b1;
        send_byte(8'h5F);
        clr_of = 1'b0;
        check("ov_full", 128'(full), 128'd1);
        check("ov_count", 128'(count), 128'd4);
        check("ov_of", 128'(of), 128'd1);
        pop_check("ov_pop1", blk(1));
        pop_check("ov_pop2", blk(2));
        pop_check("ov_pop3", blk(3));
        pop_check("ov_pop4", blk(4));
        check("ov_empty", 128'(empty), 128'd1);
        check("ov_of_sticky", 128'(of), 128'd1);
        clr_of = 1'b1;
        tick();
        clr_of = 1'b0;
        check("ov_of_clr", 128'(of), 128'd0);

        // Simultaneous push and pop on a full FIFO
        for (int k = 1; k <= 4; k++) send_block(k);
        for (int i = 0; i < 15; i++) send_byte(8'(80 + i));
        din = 8'h5F; din_valid = 1'b1; read_en = 1'b1;
        tick();
        din_valid = 1'b0;
        check("sp_dout", dout, blk(1));
        check("sp_count", 128'(count), 128'd4);
        check("sp_of", 128'(of), 128'd0);
        // Back-to-back pops, read_en held high
        for (int k = 2; k <= 5; k++) begin
            tick();
            check($sformatf("sp_b2b%0d_valid", k), 128'(dout_valid), 128'd1);
            check($sformatf("sp_b2b%0d_dout", k), dout, blk(k));
        end
        check("sp_empty", 128'(empty), 128'd1);
        tick();
        read_en = 1'b0;
        check("sp_no_extra", 128'(dout_valid), 128'd0);

        // Flush of a partial block
        for (int i = 0; i < 7; i++) send_byte(8'h11);
        check("fl_byte_cnt7", 128'(byte_cnt), 128'd7);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("fl_byte_cnt0", 128'(byte_cnt), 128'd0);
        for (int i = 0; i < 16; i++) send_byte(8'(8'hA0 + i));
        pop_check("fl_pop", 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
        // Clear together with a word: that word starts the new block
        for (int i = 0; i < 5; i++) send_byte(8'h22);
        clear = 1'b1;
        send_byte(8'hB0);
        clear = 1'b0;
        check("fl_same_byte_cnt", 128'(byte_cnt), 128'd1);
        for (int i = 1; i < 16; i++) send_byte(8'(8'hB0 + i));
        check("fl_same_count", 128'(count), 128'd1);
        pop_check("fl_same_pop", 128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF);

        // Reset with 2 blocks queued and 9 bytes partial
        send_block(6);
        send_block(7);
        for (int i = 0; i < 9; i++) send_byte(8'h33);
        check("rs_pre_count", 128'(count), 128'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rs_dout", dout, '0);
        check("rs_dout_valid", 128'(dout_valid), 128'd0);
        check("rs_empty", 128'(empty), 128'd1);
        check("rs_full", 128'(full), 128'd0);
        check("rs_count", 128'(count), 128'd0);
        check("rs_byte_cnt", 128'(byte_cnt), 128'd0);
        check("rs_of", 128'(of), 128'd0);
        // Assembly register was zeroed: a fresh block comes out intact
        send_block(9);
        pop_check("rs_fresh", blk(9));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
